rca_sum_accumulator: RTL

- Downstream consumer of the 4-bit ripple-carry adder result.
- Takes a stream of {carry, sum} words over a valid/ready handshake and accumulates COUNT of them into a wider register.
- Presents one frame total with a sticky overflow flag, then waits for the consumer to take it.
- Sits between the adder datapath and any result sink that needs multi-operand sums.

---
 rtl/rca_sum_accumulator.sv | 118 +++++++++++
 1 files changed

// File: rtl/rca_sum_accumulator.sv
// Accumulates COUNT {carry,sum} words from the ripple-carry adder into one
// ACC_W-bit frame total with a sticky overflow flag. Optional macro: RCA_ACC_SAT_EN.
module rca_sum_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ovf, ovf_n;
  logic              accept;
  logic              last;
  logic [ACC_W:0]    operand;
  logic [ACC_W:0]    sum;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready;
  // a result transfers on a rising edge where out_valid & out_ready. Both
  // sides must hold their data stable until that edge.
  assign in_ready = (state != HOLD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  assign operand = {{(ACC_W - DATA_W){1'b0}}, in_carry, in_sum};
  assign sum     = {1'b0, acc} + operand;
  assign last    = (state == IDLE) ? (COUNT == 1) : (cnt == CNT_W'(COUNT - 1));

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // First operand always fits because ACC_W >= DATA_W+1.
          if (accept) begin
            acc_n   = operand[ACC_W-1:0];
            cnt_n   = CNT_W'(1);
            state_n = last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_n = cnt + CNT_W'(1);
            if (sum[ACC_W]) ovf_n = 1'b1;
`ifdef RCA_ACC_SAT_EN
            if (sum[ACC_W] || ovf) acc_n = '1;
            else                   acc_n = sum[ACC_W-1:0];
`else
            acc_n = sum[ACC_W-1:0];
`endif
            if (last) state_n = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Result outputs are registered from the next-state values so they are
  // valid in the cycle after the final accept and zero outside HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      ovf       <= ovf_n;
      out_valid <= (state_n == HOLD);
      out_acc   <= (state_n == HOLD) ? acc_n : '0;
      out_ovf   <= (state_n == HOLD) & ovf_n;
    end
  end

endmodule
